// File: rtl/fifo_ptr_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_mem
// Purpose  : Pointer and storage stage of a synchronous FIFO. Qualifies raw
//            requests with the status-stage flags, owns the data array and
//            advances the wrap-bit extended write/read pointers.
// Revision : 1.0  initial release
// ============================================================================
module fifo_ptr_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ffull,
    input  logic              fempty,
    output logic              fwe,
    output logic              frd,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   count
);

    localparam int            c_DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              w_fwe;
    logic              w_frd;

    // Same-slot read and write in one cycle needs full or empty, so the
    // enables below already rule it out and no bypass path is required.
    assign w_fwe = wr & ~ffull;
    assign w_frd = rd & ~fempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_fwe) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_frd) begin
                r_rptr     <= r_rptr + c_PTR_ONE;
                r_data_out <= r_mem[r_rptr[ADDR_W-1:0]];
            end
            r_data_valid <= w_frd;
        end
    end

    // Storage is not reset; reset only suppresses the write in that cycle.
    always_ff @(posedge clk) begin
        if (!rst && w_fwe) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    assign fwe        = w_fwe;
    assign frd        = w_frd;
    assign wptr       = r_wptr;
    assign rptr       = r_rptr;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign count      = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: doc/fifo_ptr_mem.md
# fifo_ptr_mem

Pointer and storage stage of the synchronous FIFO. It sits directly upstream of the FIFO status stage. It gates raw write/read requests with the full/empty flags returned by the status stage, and owns the data array. It advances the extended (wrap-bit) write and read pointers and drives the qualified enables `fwe`/`frd` and pointers `wptr`/`rptr` that the status stage consumes. Read data is registered.

## Interface
Parameters:
- `DATA_W`, 8: data word width.
- `ADDR_W`, 4: address width. Depth = 2^ADDR_W = 16. Pointers are ADDR_W+1 bits, with the MSB as the wrap bit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr`  in  1  raw write request.
- `rd`  in  1  raw read request.
- `data_in`  in  DATA_W  write data, sampled when `fwe`=1.
- `ffull`  in  1  full flag from the status stage.
- `fempty`  in  1  empty flag from the status stage.
- `fwe`  out  1  qualified write enable = `wr & ~ffull` (combinational).
- `frd`  out  1  qualified read enable = `rd & ~fempty` (combinational).
- `wptr`  out  ADDR_W+1  write pointer (registered).
- `rptr`  out  ADDR_W+1  read pointer (registered).
- `data_out`  out  DATA_W  registered read data.
- `data_valid`  out  1  high for one cycle when `data_out` was updated by a read.
- `count`  out  ADDR_W+1  occupancy = `wptr - rptr` mod 2^(ADDR_W+1); range 0..16.

## Operation
- Storage: array of 2^ADDR_W words of DATA_W bits.
  - Indexed by `wptr[ADDR_W-1:0]` for writes and `rptr[ADDR_W-1:0]` for reads.
  - Array contents are not reset.
- Reset (`rst`=1 at the edge) sets: `wptr`=0, `rptr`=0, `data_out`=0, `data_valid`=0.
  - Reset overrides any concurrent `wr`/`rd`; no array write occurs in the reset cycle.
- Write: if `fwe`, then `mem[wptr[3:0]] <= data_in` and `wptr <= wptr+1`.
- Read: if `frd`, then `data_out <= mem[rptr[3:0]]` and `rptr <= rptr+1`.
- `data_valid <= frd` every non-reset cycle.
- If `frd`=0, `data_out` holds its previous value.
- Pointer arithmetic is modulo 2^(ADDR_W+1): 31 wraps to 0, and the MSB toggles every 16 accesses.
- Boundary rules:
  - Write while full: `fwe`=0; the array and `wptr` are unchanged; the data is dropped. Overflow flagging belongs to the status stage.
  - Read while empty: `frd`=0; `rptr`, `data_out` are unchanged and `data_valid`=0.
  - Simultaneous `wr`&`rd`, not full and not empty: both proceed and `count` is unchanged.
  - Simultaneous `wr`&`rd` at full: the read proceeds and the write is blocked. The freed slot is writable from the next cycle.
  - Simultaneous `wr`&`rd` at empty: the write proceeds and the read is blocked. There is no fall-through.
  - Same-slot read and write cannot occur in one cycle, because that requires full or empty; no bypass logic is needed.
- `ffull`/`fempty` are derived combinationally from the registered pointers, so the enable loop closes through registers only.

## Timing
- Write latency: data presented with `fwe`=1 at edge N is readable by a read issued at edge N+1 or later.
- Read latency: with `frd`=1 at edge N, `data_out` and `data_valid`=1 are valid after edge N, i.e. during cycle N+1.
- Throughput: one write and one read per cycle.
- `count`, `fwe` and `frd` settle combinationally within the same cycle after pointers or requests change.
- Back-to-back reads give a `data_valid` pulse train with no bubbles.

## Test plan
- Reset: assert `rst` for 2 cycles with `wr`=`rd`=1. Required: `wptr`=`rptr`=0, `count`=0, `data_valid`=0, `data_out`=0, and no array write.
- Fill/overflow block: write 0x00..0x0F on 16 cycles, then try a 17th write of 0xAA. Required: `count`=16 and `fwe`=0 on the 17th write; `wptr` stays at 16 (0b10000).
- Drain in order: read 17 times. Required:
  - `data_out` = 0x00..0x0F with `data_valid`=1, one cycle after each `frd`.
  - The 17th read gives `frd`=0 and `data_valid`=0, with `data_out` holding 0x0F.
- Wrap-around: stream 40 write-then-read pairs with data = index. Required:
  - Pointers wrap 31 to 0 and the MSB toggles at 16 and 32.
  - All 40 values come out in order.
- Simultaneous events:
  - At count=5, `wr`&`rd` for 10 cycles: count stays 5.
  - At full, `wr`&`rd`: count becomes 15 and the written word is not stored.
  - At empty, `wr`&`rd`: count becomes 1 and `data_valid`=0.
- Reset mid-operation: at count=9, assert `rst` while `wr`=`rd`=1. Required: next-cycle `wptr`=`rptr`=0, `count`=0, `data_valid`=0, and a subsequent read is blocked (empty).
